// File: rtl/fifo_rd_packer.sv
// Drains a synchronous FIFO with one-cycle read latency and packs PACK words
// into one wide word with a lane mask, emitted on a valid/ready handshake.
module fifo_rd_packer #(
   parameter int DATA_W = 16,
   parameter int PACK   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fifo_empty,
   output logic                   fifo_rd_en,
   input  logic [DATA_W-1:0]      fifo_dout,
   input  logic                   fifo_valid,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W*PACK-1:0] out_data,
   output logic [PACK-1:0]        out_keep,
   output logic                   protocol_err
);

   localparam int CW = $clog2(PACK + 1);
   localparam int LW = $clog2(PACK);

   typedef enum logic {FILL, SEND} state_t;

   state_t                       state_q;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic                         inflight_q;
   logic                         flush_pend_q;
   logic                         out_valid_q;
   logic                         protocol_err_q;
   logic [PACK-1:0][DATA_W-1:0]  lanes_q;
   logic [PACK-1:0]              keep_q;
   logic [CW:0]                  in_use;
   logic                         capture;
   logic                         flush_req;
   logic                         go_send;

   always_comb begin
      capture   = fifo_valid && inflight_q;
      cnt_d     = cnt_q + CW'(capture);
      flush_req = flush || flush_pend_q;
      in_use    = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};
      // A flush this cycle also blocks the read so no word lands after the partial word leaves.
      fifo_rd_en = (state_q == FILL) && !fifo_empty && (in_use < (CW+1)'(PACK)) && !flush_req;
      go_send    = (state_q == FILL) &&
                   ((cnt_d == CW'(PACK)) ||
                    (flush_req && (!inflight_q || capture) && (cnt_d != '0)));
   end

   // NOTE: the lane registers are reset and cleared after every word so unfilled lanes always read as zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= FILL;
         cnt_q          <= '0;
         inflight_q     <= 1'b0;
         flush_pend_q   <= 1'b0;
         out_valid_q    <= 1'b0;
         protocol_err_q <= 1'b0;
         lanes_q        <= '0;
         keep_q         <= '0;
      end else begin
         inflight_q <= fifo_rd_en;
         if (fifo_valid && !inflight_q)
            protocol_err_q <= 1'b1;

         case (state_q)
            FILL: begin
               if (capture) begin
                  lanes_q[cnt_q[LW-1:0]] <= fifo_dout;
                  keep_q[cnt_q[LW-1:0]]  <= 1'b1;
                  cnt_q                  <= cnt_d;
               end
               if (go_send) begin
                  state_q      <= SEND;
                  out_valid_q  <= 1'b1;
                  flush_pend_q <= 1'b0;
               end else if (flush && inflight_q) begin
                  flush_pend_q <= 1'b1;
               end else if (flush_pend_q && !inflight_q) begin
                  // Pending flush with nothing captured: drop it rather than block reads forever.
                  flush_pend_q <= 1'b0;
               end
            end
            SEND: begin
               if (out_ready) begin
                  state_q      <= FILL;
                  out_valid_q  <= 1'b0;
                  cnt_q        <= '0;
                  keep_q       <= '0;
                  lanes_q      <= '0;
                  flush_pend_q <= 1'b0;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = lanes_q;
   assign out_keep     = keep_q;
   assign protocol_err = protocol_err_q;

endmodule
